// File: rtl/midi_rx_fifo_if.sv
// rtl/midi_rx_fifo_if.sv - byte-in / bus-read interface bundle for midi_rx_fifo
interface midi_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          uart_data;
  logic                uart_data_rdy;
  logic                bus_rd;
  logic [7:0]          bus_dat;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_empty;
  logic                fifo_full;
  logic                overflow;
  logic                ovf_clr;
  logic                irq;

  modport master (
    output uart_data, uart_data_rdy, bus_rd, ovf_clr,
    input  bus_dat, fifo_count, fifo_empty, fifo_full, overflow, irq
  );

  modport slave (
    input  uart_data, uart_data_rdy, bus_rd, ovf_clr,
    output bus_dat, fifo_count, fifo_empty, fifo_full, overflow, irq
  );
endinterface

// File: rtl/midi_rx_fifo.sv
// rtl/midi_rx_fifo.sv - MIDI receive byte FIFO with sticky overflow and level irq
// Optional: define MIDI_RX_FIFO_AS_FILTER_EN to drop Active Sensing (0xFE) bytes on entry.
module midi_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_THRESH = 1
) (
  input  logic          clk,
  input  logic          reset,
  midi_rx_fifo_if.slave bus
);
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          rdy_q;
  logic          wr_req, do_wr, do_rd, drop, ovf_nxt;

  // Edge-detect the ready so a held level still yields exactly one byte.
`ifdef MIDI_RX_FIFO_AS_FILTER_EN
  assign wr_req = bus.uart_data_rdy & ~rdy_q & (bus.uart_data != 8'hFE);
`else
  assign wr_req = bus.uart_data_rdy & ~rdy_q;
`endif

  always_comb begin
    do_rd     = 1'b0;
    do_wr     = 1'b0;
    drop      = 1'b0;
    count_nxt = count;
    do_rd     = bus.bus_rd & (count != '0);
    // At full a concurrent pop frees the slot the write needs.
    do_wr     = wr_req & ((count != CW'(DEPTH)) | do_rd);
    drop      = wr_req & ~do_wr;
    count_nxt = count + CW'(do_wr) - CW'(do_rd);
    ovf_nxt   = drop | (bus.overflow & ~bus.ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= bus.uart_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q          <= 1'b1;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.bus_dat    <= 8'h00;
      bus.fifo_empty <= 1'b1;
      bus.fifo_full  <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.irq        <= 1'b0;
    end else begin
      rdy_q <= bus.uart_data_rdy;
      if (do_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_rd) begin
        rd_ptr      <= rd_ptr + PW'(1);
        bus.bus_dat <= mem[rd_ptr];
      end
      count          <= count_nxt;
      bus.fifo_empty <= (count_nxt == '0);
      bus.fifo_full  <= (count_nxt == CW'(DEPTH));
      bus.overflow   <= ovf_nxt;
      bus.irq        <= (count_nxt >= CW'(IRQ_THRESH)) | ovf_nxt;
    end
  end

  assign bus.fifo_count = count;
endmodule

// File: tb/tb_midi_rx_fifo.sv
// tb/tb_midi_rx_fifo.sv - directed self-checking bench for midi_rx_fifo
module tb_midi_rx_fifo;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  midi_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  midi_rx_fifo #(.DEPTH_LOG2(4), .IRQ_THRESH(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    bus.uart_data     = b;
    bus.uart_data_rdy = 1'b1;
    @(negedge clk);
    bus.uart_data_rdy = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    bus.bus_rd = 1'b1;
    @(negedge clk);
    bus.bus_rd = 1'b0;
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.uart_data     = 8'h00;
    bus.uart_data_rdy = 1'b0;
    bus.bus_rd        = 1'b0;
    bus.ovf_clr       = 1'b0;

    do_reset();
    check_eq("rst_count", 32'(bus.fifo_count), 32'd0);
    check_eq("rst_empty", 32'(bus.fifo_empty), 32'd1);
    check_eq("rst_full",  32'(bus.fifo_full),  32'd0);
    check_eq("rst_ovf",   32'(bus.overflow),   32'd0);
    check_eq("rst_irq",   32'(bus.irq),        32'd0);
    check_eq("rst_dat",   32'(bus.bus_dat),    32'h00);

    write_byte(8'hDE);
    check_eq("one_count", 32'(bus.fifo_count), 32'd1);
    check_eq("one_irq",   32'(bus.irq),        32'd1);
    check_eq("one_empty", 32'(bus.fifo_empty), 32'd0);
    pop();
    check_eq("one_dat",   32'(bus.bus_dat),    32'hDE);
    check_eq("one_empty2",32'(bus.fifo_empty), 32'd1);
    check_eq("one_irq2",  32'(bus.irq),        32'd0);

    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check_eq("fill_full",  32'(bus.fifo_full),  32'd1);
    check_eq("fill_count", 32'(bus.fifo_count), 32'd16);
    check_eq("fill_ovf",   32'(bus.overflow),   32'd0);
    write_byte(8'h99);
    check_eq("ovf_set",    32'(bus.overflow),   32'd1);
    check_eq("ovf_count",  32'(bus.fifo_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop();
      check_eq($sformatf("drain_%0d", i), 32'(bus.bus_dat), 32'(i));
    end
    check_eq("drain_empty", 32'(bus.fifo_empty), 32'd1);
    check_eq("drain_irq",   32'(bus.irq),        32'd1);
    clear_ovf();
    check_eq("clr_ovf", 32'(bus.overflow), 32'd0);
    check_eq("clr_irq", 32'(bus.irq),      32'd0);

    // Pointers now sit at 1, so this fill wraps the storage index.
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    @(negedge clk);
    bus.uart_data     = 8'h55;
    bus.uart_data_rdy = 1'b1;
    bus.bus_rd        = 1'b1;
    @(negedge clk);
    bus.uart_data_rdy = 1'b0;
    bus.bus_rd        = 1'b0;
    check_eq("wrfull_dat",   32'(bus.bus_dat),    32'h00);
    check_eq("wrfull_count", 32'(bus.fifo_count), 32'd16);
    check_eq("wrfull_ovf",   32'(bus.overflow),   32'd0);
    check_eq("wrfull_full",  32'(bus.fifo_full),  32'd1);
    for (int i = 1; i < 16; i++) begin
      pop();
      check_eq($sformatf("wrap_%0d", i), 32'(bus.bus_dat), 32'(i));
    end
    pop();
    check_eq("wrap_last",  32'(bus.bus_dat),    32'h55);
    check_eq("wrap_empty", 32'(bus.fifo_empty), 32'd1);

    @(negedge clk);
    bus.uart_data     = 8'h21;
    bus.uart_data_rdy = 1'b1;
    bus.bus_rd        = 1'b1;
    @(negedge clk);
    bus.uart_data_rdy = 1'b0;
    bus.bus_rd        = 1'b0;
    check_eq("wrempty_dat",   32'(bus.bus_dat),    32'h55);
    check_eq("wrempty_count", 32'(bus.fifo_count), 32'd1);
    pop();
    check_eq("wrempty_pop",   32'(bus.bus_dat),    32'h21);

    @(negedge clk);
    bus.uart_data     = 8'h90;
    bus.uart_data_rdy = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("held_count", 32'(bus.fifo_count), 32'd1);
    do_reset();
    check_eq("held_rst_count", 32'(bus.fifo_count), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("held_after_count", 32'(bus.fifo_count), 32'd0);
    bus.uart_data_rdy = 1'b0;
    pop();
    check_eq("empty_rd_dat",   32'(bus.bus_dat),    32'h00);
    check_eq("empty_rd_count", 32'(bus.fifo_count), 32'd0);

    for (int i = 0; i < 16; i++) write_byte(8'(8'h40 + i));
    @(negedge clk);
    bus.uart_data     = 8'h77;
    bus.uart_data_rdy = 1'b1;
    bus.ovf_clr       = 1'b1;
    @(negedge clk);
    bus.uart_data_rdy = 1'b0;
    bus.ovf_clr       = 1'b0;
    check_eq("setwins_ovf", 32'(bus.overflow), 32'd1);
    clear_ovf();
    check_eq("clr2_ovf",   32'(bus.overflow),   32'd0);
    check_eq("clr2_irq",   32'(bus.irq),        32'd1);
    check_eq("clr2_count", 32'(bus.fifo_count), 32'd16);
    pop();
    check_eq("clr2_head",  32'(bus.bus_dat),    32'h40);

    do_reset();
    write_byte(8'hFE);
    write_byte(8'h3C);
`ifdef MIDI_RX_FIFO_AS_FILTER_EN
    check_eq("filt_count", 32'(bus.fifo_count), 32'd1);
    pop();
    check_eq("filt_dat0",  32'(bus.bus_dat),    32'h3C);
`else
    check_eq("filt_count", 32'(bus.fifo_count), 32'd2);
    pop();
    check_eq("filt_dat0",  32'(bus.bus_dat),    32'hFE);
    pop();
    check_eq("filt_dat1",  32'(bus.bus_dat),    32'h3C);
`endif
    check_eq("filt_empty", 32'(bus.fifo_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
